// File: rtl/sc_score_pkg.sv
// Shared types and helpers for the note scoring engine.
// Latency: n/a (package only).
// Backpressure: n/a.
package sc_score_pkg;

    // Per-lane grade produced by stage 1. Explicit misses and late hits share
    // LATE because stage 2 counts them identically.
    typedef enum logic [2:0] {
        TIER0 = 3'd0,
        TIER1 = 3'd1,
        TIER2 = 3'd2,
        TIER3 = 3'd3,
        LATE  = 3'd4,
        NONE  = 3'd5
    } tier_e;

    // Default tier upper bounds (10 ms ticks) and base points
    localparam int DEF_T0 = 10;
    localparam int DEF_T1 = 25;
    localparam int DEF_T2 = 50;
    localparam int DEF_T3 = 100;
    localparam int DEF_P0 = 100;
    localparam int DEF_P1 = 50;
    localparam int DEF_P2 = 25;
    localparam int DEF_P3 = 10;

    // a + b clamped to the all-ones value of a w-bit field (w <= 64)
    function automatic logic [63:0] sat_add(input logic [63:0] a,
                                            input logic [63:0] b,
                                            input int unsigned w);
        logic [64:0] sum;
        logic [63:0] lim;
        sum = {1'b0, a} + {1'b0, b};
        lim = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[63:0];
    endfunction

endpackage

// File: rtl/sc_tier_classify.sv
// Stage 1: grade one lane's match/miss strobe by timing error and register it.
// Latency: 1 cycle.
// Backpressure: none; a new grade is accepted every cycle.
module sc_tier_classify
    import sc_score_pkg::*;
#(
    parameter int DT_W = 16,
    parameter int T0   = DEF_T0,
    parameter int T1   = DEF_T1,
    parameter int T2   = DEF_T2,
    parameter int T3   = DEF_T3
) (
    input  logic            clk,
    input  logic            flush_i,
    input  logic            match_en_i,
    input  logic            miss_i,
    input  logic [DT_W-1:0] dt_i,
    output tier_e           tier_o
);

    localparam logic [DT_W-1:0] T0_C = DT_W'(T0);
    localparam logic [DT_W-1:0] T1_C = DT_W'(T1);
    localparam logic [DT_W-1:0] T2_C = DT_W'(T2);
    localparam logic [DT_W-1:0] T3_C = DT_W'(T3);

    tier_e tier_d, tier_q;

    // Grade the lane; an explicit miss overrides a simultaneous match
    always_comb begin
        tier_d = NONE;
        if (miss_i) begin
            tier_d = LATE;
        end else if (match_en_i) begin
            if (dt_i < T0_C)      tier_d = TIER0;
            else if (dt_i < T1_C) tier_d = TIER1;
            else if (dt_i < T2_C) tier_d = TIER2;
            else if (dt_i < T3_C) tier_d = TIER3;
            else                  tier_d = LATE;
        end
    end

    // Stage-1 register; a flush discards both the held and the incoming grade
    always_ff @(posedge clk) begin
        if (flush_i) tier_q <= NONE;
        else         tier_q <= tier_d;
    end

    assign tier_o = tier_q;

endmodule

// File: rtl/sc_score_engine.sv
// Multi-lane scoring: grades hits per lane, then scores, tracks combo/multiplier and stats.
// Latency: 2 cycles from input strobes to all registered outputs.
// Backpressure: none; one event set per cycle. SC_SCORE_HIST_EN adds per-tier hit counters.
module sc_score_engine
    import sc_score_pkg::*;
#(
    parameter int LANES      = 5,
    parameter int DT_W       = 16,
    parameter int SCORE_W    = 32,
    parameter int COMBO_W    = 16,
    parameter int T0         = DEF_T0,
    parameter int T1         = DEF_T1,
    parameter int T2         = DEF_T2,
    parameter int T3         = DEF_T3,
    parameter int P0         = DEF_P0,
    parameter int P1         = DEF_P1,
    parameter int P2         = DEF_P2,
    parameter int P3         = DEF_P3,
    parameter int COMBO_STEP = 10,
    parameter int MAX_MULT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LANES-1:0]      match_en,
    input  logic [LANES*DT_W-1:0] match_dt,
    input  logic [LANES-1:0]      miss,
    input  logic                  clear,
    output logic [SCORE_W-1:0]    score,
    output logic [COMBO_W-1:0]    combo,
    output logic [COMBO_W-1:0]    max_combo,
    output logic [3:0]            mult,
    output logic [COMBO_W-1:0]    hit_count,
    output logic [COMBO_W-1:0]    miss_count,
    output logic                  evt_valid
`ifdef SC_SCORE_HIST_EN
    ,
    output logic [COMBO_W-1:0]    tier_cnt0,
    output logic [COMBO_W-1:0]    tier_cnt1,
    output logic [COMBO_W-1:0]    tier_cnt2,
    output logic [COMBO_W-1:0]    tier_cnt3
`endif
);

    logic  flush;
    tier_e tier_w [LANES];

    assign flush = rst | clear;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        sc_tier_classify #(
            .DT_W (DT_W), .T0 (T0), .T1 (T1), .T2 (T2), .T3 (T3)
        ) u_cls (
            .clk        (clk),
            .flush_i    (flush),
            .match_en_i (match_en[g]),
            .miss_i     (miss[g]),
            .dt_i       (match_dt[g*DT_W +: DT_W]),
            .tier_o     (tier_w[g])
        );
    end

    logic [SCORE_W-1:0] score_q, score_d;
    logic [COMBO_W-1:0] combo_q, combo_d, max_combo_q, max_combo_d;
    logic [COMBO_W-1:0] step_q, step_d;
    logic [3:0]         mult_q, mult_d;
    logic [COMBO_W-1:0] hit_q, hit_d, miss_q, miss_d;
    logic               evt_q, evt_d;
    logic [3:0]         h_cnt, m_cnt;
    logic [31:0]        pts;
    logic [63:0]        prod;
    logic [COMBO_W:0]   step_sum;
`ifdef SC_SCORE_HIST_EN
    logic [3:0]         th [4];
    logic [COMBO_W-1:0] tc_q [4];
    logic [COMBO_W-1:0] tc_d [4];
`endif

    // Stage 2: aggregate lane grades and compute next accumulator state
    always_comb begin
        h_cnt = '0;
        m_cnt = '0;
        pts   = '0;
`ifdef SC_SCORE_HIST_EN
        for (int t = 0; t < 4; t++) th[t] = '0;
`endif
        for (int i = 0; i < LANES; i++) begin
            case (tier_w[i])
                TIER0:   begin h_cnt = h_cnt + 4'd1; pts = pts + 32'(P0); end
                TIER1:   begin h_cnt = h_cnt + 4'd1; pts = pts + 32'(P1); end
                TIER2:   begin h_cnt = h_cnt + 4'd1; pts = pts + 32'(P2); end
                TIER3:   begin h_cnt = h_cnt + 4'd1; pts = pts + 32'(P3); end
                LATE:    m_cnt = m_cnt + 4'd1;
                default: ;
            endcase
`ifdef SC_SCORE_HIST_EN
            if (tier_w[i] <= TIER3) th[tier_w[i][1:0]] = th[tier_w[i][1:0]] + 4'd1;
`endif
        end

        // Points are weighted by the multiplier in force before this event set
        prod    = 64'(pts) * 64'(mult_q);
        score_d = SCORE_W'(sat_add(64'(score_q), prod, SCORE_W));

        step_sum = {1'b0, step_q} + (COMBO_W+1)'(h_cnt);
        combo_d  = COMBO_W'(sat_add(64'(combo_q), 64'(h_cnt), COMBO_W));
        step_d   = step_sum[COMBO_W-1:0];
        mult_d   = mult_q;
        if (m_cnt != '0) begin
            // Any miss breaks the streak, even if other lanes hit
            combo_d = '0;
            step_d  = '0;
            mult_d  = 4'd1;
        end else if (step_sum >= (COMBO_W+1)'(COMBO_STEP)) begin
            // LANES <= COMBO_STEP bounds this to one increment per cycle
            step_d = COMBO_W'(step_sum - (COMBO_W+1)'(COMBO_STEP));
            if (mult_q < 4'(MAX_MULT)) mult_d = mult_q + 4'd1;
        end

        max_combo_d = (combo_d > max_combo_q) ? combo_d : max_combo_q;
        hit_d  = COMBO_W'(sat_add(64'(hit_q), 64'(h_cnt), COMBO_W));
        miss_d = COMBO_W'(sat_add(64'(miss_q), 64'(m_cnt), COMBO_W));
        evt_d  = (h_cnt != '0) || (m_cnt != '0);
`ifdef SC_SCORE_HIST_EN
        for (int t = 0; t < 4; t++) tc_d[t] = COMBO_W'(sat_add(64'(tc_q[t]), 64'(th[t]), COMBO_W));
`endif
    end

    // Stage-2 registers; rst and clear both return to the song-start state
    always_ff @(posedge clk) begin
        if (flush) begin
            score_q     <= '0;
            combo_q     <= '0;
            max_combo_q <= '0;
            step_q      <= '0;
            mult_q      <= 4'd1;
            hit_q       <= '0;
            miss_q      <= '0;
            evt_q       <= 1'b0;
`ifdef SC_SCORE_HIST_EN
            for (int t = 0; t < 4; t++) tc_q[t] <= '0;
`endif
        end else begin
            score_q     <= score_d;
            combo_q     <= combo_d;
            max_combo_q <= max_combo_d;
            step_q      <= step_d;
            mult_q      <= mult_d;
            hit_q       <= hit_d;
            miss_q      <= miss_d;
            evt_q       <= evt_d;
`ifdef SC_SCORE_HIST_EN
            for (int t = 0; t < 4; t++) tc_q[t] <= tc_d[t];
`endif
        end
    end

    assign score      = score_q;
    assign combo      = combo_q;
    assign max_combo  = max_combo_q;
    assign mult       = mult_q;
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
    assign evt_valid  = evt_q;
`ifdef SC_SCORE_HIST_EN
    assign tier_cnt0  = tc_q[0];
    assign tier_cnt1  = tc_q[1];
    assign tier_cnt2  = tc_q[2];
    assign tier_cnt3  = tc_q[3];
`endif

endmodule

// File: tb/tb_sc_score_engine.sv
// Scoreboard bench for sc_score_engine: reference model pushes expected state per event set,
// a monitor pops and compares on every evt_valid pulse.
// SCORE_W is reduced to 16 so score saturation is reachable in a short run.
module tb_sc_score_engine;

    localparam int LANES   = 5;
    localparam int DT_W    = 16;
    localparam int SCORE_W = 16;
    localparam int COMBO_W = 16;
    localparam longint SMAX = (64'd1 << SCORE_W) - 1;
    localparam longint CMAX = (64'd1 << COMBO_W) - 1;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [LANES-1:0]      match_en = '0;
    logic [LANES*DT_W-1:0] match_dt = '0;
    logic [LANES-1:0]      miss = '0;
    logic                  clear = 1'b0;
    logic [SCORE_W-1:0]    score;
    logic [COMBO_W-1:0]    combo, max_combo, hit_count, miss_count;
    logic [3:0]            mult;
    logic                  evt_valid;
`ifdef SC_SCORE_HIST_EN
    logic [COMBO_W-1:0]    tier_cnt0, tier_cnt1, tier_cnt2, tier_cnt3;
`endif

    always #5 clk = ~clk;

    sc_score_engine #(.LANES(LANES), .DT_W(DT_W), .SCORE_W(SCORE_W), .COMBO_W(COMBO_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .match_en   (match_en),
        .match_dt   (match_dt),
        .miss       (miss),
        .clear      (clear),
        .score      (score),
        .combo      (combo),
        .max_combo  (max_combo),
        .mult       (mult),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .evt_valid  (evt_valid)
`ifdef SC_SCORE_HIST_EN
        ,
        .tier_cnt0  (tier_cnt0),
        .tier_cnt1  (tier_cnt1),
        .tier_cnt2  (tier_cnt2),
        .tier_cnt3  (tier_cnt3)
`endif
    );

    typedef struct {
        longint sc, cb, mc, mu, hc, ms;
        longint t0, t1, t2, t3;
    } exp_t;

    exp_t   q[$];
    int     total = 0;
    int     bad   = 0;

    // Reference model state
    longint m_score, m_combo, m_maxc, m_mult, m_step, m_hits, m_miss;
    longint m_tc [4];

    // Event set captured in the previous cycle, not yet known to survive a clear
    bit                    pend_vld = 0;
    logic [LANES-1:0]      pend_en, pend_mis;
    logic [LANES*DT_W-1:0] pend_dt;
    bit                    chk_reset_next = 0;

    logic [DT_W-1:0] dtab [12] = '{16'd0, 16'd5, 16'd9, 16'd10, 16'd24, 16'd25,
                                   16'd49, 16'd50, 16'd99, 16'd100, 16'd101, 16'hFFFF};

    task automatic chk(input string nm, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req);
        end
    endtask

    function automatic longint lmin(input longint a, input longint b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        m_score = 0; m_combo = 0; m_maxc = 0; m_mult = 1; m_step = 0;
        m_hits = 0; m_miss = 0;
        for (int t = 0; t < 4; t++) m_tc[t] = 0;
    endtask

    // Scoring rules applied to one surviving event set
    task automatic model_apply(input logic [LANES-1:0] en, input logic [LANES-1:0] mis,
                               input logic [LANES*DT_W-1:0] dts);
        longint h, m, p, d;
        exp_t e;
        h = 0; m = 0; p = 0;
        for (int i = 0; i < LANES; i++) begin
            d = longint'(dts[i*DT_W +: DT_W]);
            if (mis[i]) m++;
            else if (en[i]) begin
                if (d < 10)       begin h++; p += 100; m_tc[0]++; end
                else if (d < 25)  begin h++; p += 50;  m_tc[1]++; end
                else if (d < 50)  begin h++; p += 25;  m_tc[2]++; end
                else if (d < 100) begin h++; p += 10;  m_tc[3]++; end
                else m++;
            end
        end
        m_score = lmin(m_score + p * m_mult, SMAX);
        if (m > 0) begin
            m_combo = 0; m_step = 0; m_mult = 1;
        end else begin
            m_combo = lmin(m_combo + h, CMAX);
            m_step  = m_step + h;
            if (m_step >= 10) begin
                m_step = m_step - 10;
                m_mult = lmin(m_mult + 1, 4);
            end
        end
        if (m_combo > m_maxc) m_maxc = m_combo;
        m_hits = lmin(m_hits + h, CMAX);
        m_miss = lmin(m_miss + m, CMAX);
        for (int t = 0; t < 4; t++) m_tc[t] = lmin(m_tc[t], CMAX);
        if (h + m > 0) begin
            e.sc = m_score; e.cb = m_combo; e.mc = m_maxc; e.mu = m_mult;
            e.hc = m_hits;  e.ms = m_miss;
            e.t0 = m_tc[0]; e.t1 = m_tc[1]; e.t2 = m_tc[2]; e.t3 = m_tc[3];
            q.push_back(e);
        end
    endtask

    task automatic check_reset_state();
        chk("rst_score", longint'(score), 0);
        chk("rst_combo", longint'(combo), 0);
        chk("rst_max_combo", longint'(max_combo), 0);
        chk("rst_mult", longint'(mult), 1);
        chk("rst_hits", longint'(hit_count), 0);
        chk("rst_miss", longint'(miss_count), 0);
        chk("rst_evt", longint'(evt_valid), 0);
`ifdef SC_SCORE_HIST_EN
        chk("rst_tc0", longint'(tier_cnt0), 0);
`endif
    endtask

    // One input cycle, driven at the falling edge
    task automatic issue(input logic [LANES-1:0] en, input logic [LANES-1:0] mis,
                         input logic [LANES*DT_W-1:0] dts, input bit clr, input bit rs);
        @(negedge clk);
        if (chk_reset_next) check_reset_state();
        match_en = en; miss = mis; match_dt = dts; clear = clr; rst = rs;
        if (clr || rs) begin
            pend_vld = 0;
            model_reset();
            chk_reset_next = 1;
        end else begin
            if (pend_vld) model_apply(pend_en, pend_mis, pend_dt);
            pend_vld = 1; pend_en = en; pend_mis = mis; pend_dt = dts;
            chk_reset_next = 0;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue('0, '0, '0, 1'b0, 1'b0);
    endtask

    function automatic logic [LANES*DT_W-1:0] lane_dt(input int lane, input int dt);
        logic [LANES*DT_W-1:0] v;
        v = '0;
        v[lane*DT_W +: DT_W] = DT_W'(dt);
        return v;
    endfunction

    // Monitor: compare every output pulse against the oldest expected entry
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (evt_valid) begin
                if (q.size() == 0) begin
                    total++; bad++;
                    $display("FAIL evt_unexpected actual=1 required=0");
                end else begin
                    e = q.pop_front();
                    chk("score", longint'(score), e.sc);
                    chk("combo", longint'(combo), e.cb);
                    chk("max_combo", longint'(max_combo), e.mc);
                    chk("mult", longint'(mult), e.mu);
                    chk("hit_count", longint'(hit_count), e.hc);
                    chk("miss_count", longint'(miss_count), e.ms);
`ifdef SC_SCORE_HIST_EN
                    chk("tier_cnt0", longint'(tier_cnt0), e.t0);
                    chk("tier_cnt1", longint'(tier_cnt1), e.t1);
                    chk("tier_cnt2", longint'(tier_cnt2), e.t2);
                    chk("tier_cnt3", longint'(tier_cnt3), e.t3);
`endif
                end
            end
        end
    end

    initial begin
        logic [LANES-1:0]      en, mis;
        logic [LANES*DT_W-1:0] dts;
        int r;
        model_reset();
        issue('0, '0, '0, 1'b0, 1'b1);
        issue('0, '0, '0, 1'b0, 1'b1);
        idle(1);

        // Single tier-0 hit
        issue(5'b00001, '0, lane_dt(0, 5), 1'b0, 1'b0);
        idle(2);
        chk("t1_score", longint'(score), 100);
        chk("t1_combo", longint'(combo), 1);
        chk("t1_hits", longint'(hit_count), 1);

        // Eleven tier-2 hits: multiplier steps to 2 on the tenth
        issue('0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 11; i++) issue(5'b00100, '0, lane_dt(2, 30), 1'b0, 1'b0);
        idle(2);
        chk("t2_score", longint'(score), 300);
        chk("t2_mult", longint'(mult), 2);

        // Combo of 7, then a hit and a miss together
        issue('0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) issue(5'b00001, '0, lane_dt(0, 5), 1'b0, 1'b0);
        issue(5'b00001, 5'b00010, lane_dt(0, 5), 1'b0, 1'b0);
        idle(2);
        chk("t3_score", longint'(score), 800);
        chk("t3_combo", longint'(combo), 0);
        chk("t3_max_combo", longint'(max_combo), 7);
        chk("t3_miss", longint'(miss_count), 1);

        // Tier-3 boundary: dt=100 is late, dt=99 is worth 10
        issue('0, '0, '0, 1'b1, 1'b0);
        issue(5'b01000, '0, lane_dt(3, 100), 1'b0, 1'b0);
        issue(5'b01000, '0, lane_dt(3, 99), 1'b0, 1'b0);
        idle(2);
        chk("t4_score", longint'(score), 10);
        chk("t4_miss", longint'(miss_count), 1);

        // Score saturation with all lanes hitting tier 0
        issue('0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 60; i++) issue('1, '0, '0, 1'b0, 1'b0);
        idle(2);
        chk("t5_score_sat", longint'(score), SMAX);

        // A hit followed by clear, then by rst, is discarded
        issue(5'b00001, '0, lane_dt(0, 5), 1'b0, 1'b0);
        issue('0, '0, '0, 1'b1, 1'b0);
        idle(2);
        issue(5'b00001, '0, lane_dt(0, 5), 1'b0, 1'b0);
        issue('0, '0, '0, 1'b0, 1'b1);
        idle(2);

        // Randomized traffic with thresholds-heavy dt values and occasional restarts
        for (int c = 0; c < 500; c++) begin
            en = '0; mis = '0; dts = '0;
            for (int l = 0; l < LANES; l++) begin
                r = $urandom_range(0, 19);
                if (r < 9) en[l] = 1'b1;
                if (r == 9 || r == 10) mis[l] = 1'b1;
                if (r == 10) en[l] = 1'b1;
                dts[l*DT_W +: DT_W] = ($urandom_range(0, 3) == 0) ? DT_W'($urandom_range(0, 120))
                                                                   : dtab[$urandom_range(0, 11)];
            end
            issue(en, mis, dts, ($urandom_range(0, 59) == 0), ($urandom_range(0, 149) == 0));
        end
        idle(3);
        chk("queue_drained", longint'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
